// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg : shared FP16 constants and bridge state type       rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fpu_pkg;

  localparam int          FP16_W    = 16;
  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [15:0] FP16_PINF = 16'h7C00;

  typedef enum logic [0:0] {
    DRAIN = 1'b0,
    RUN   = 1'b1
  } bridge_state_e;

endpackage

`default_nettype wire

// File: rtl/fpu_sync_fifo.sv
// ---------------------------------------------------------------------------
// fpu_sync_fifo : synchronous FIFO with registered head output  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fpu_sync_fifo
  import fpu_pkg::*;
#(
  parameter int DATA_W = FP16_W,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          din,
  input  logic                       pop,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     rd_nxt;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_nxt  = rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // dout always mirrors the current head; it is reloaded whenever the head
  // changes so a push only becomes visible on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_nxt;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (do_pop) begin
        if (count > CNT_W'(1)) dout <= mem[rd_nxt];
        else if (do_push)      dout <= din;
      end else if (empty && do_push) begin
        dout <= din;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fpu_axis_credit_bridge.sv
// ---------------------------------------------------------------------------
// fpu_axis_credit_bridge : AXI-stream credit bridge around a fixed-latency,
// no-backpressure FP16 pipe                                    rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fpu_axis_credit_bridge
  import fpu_pkg::*;
#(
  parameter int DATA_W = FP16_W,
  parameter int LAT    = 7,
  parameter int DEPTH  = 8
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [DATA_W-1:0]       s_axis_a_tdata,
  input  logic                    s_axis_a_tvalid,
  output logic                    s_axis_a_tready,
  input  logic [DATA_W-1:0]       s_axis_b_tdata,
  input  logic                    s_axis_b_tvalid,
  output logic                    s_axis_b_tready,
  output logic [DATA_W-1:0]       p_a_tdata,
  output logic [DATA_W-1:0]       p_b_tdata,
  output logic                    p_tvalid,
  input  logic [DATA_W-1:0]       p_result_tdata,
  input  logic                    p_result_tvalid,
  output logic [DATA_W-1:0]       m_axis_result_tdata,
  output logic                    m_axis_result_tvalid,
  input  logic                    m_axis_result_tready,
  output logic                    err_unexpected,
  output logic [$clog2(DEPTH):0]  used_cnt
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int DRN_W = (LAT < 1) ? 1 : $clog2(LAT + 1);

  localparam logic [0:0]       ST_DRAIN   = 1'(DRAIN);
  localparam logic [0:0]       ST_RUN     = 1'(RUN);
  localparam logic [CNT_W-1:0] CREDITS    = CNT_W'(DEPTH);
  localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(LAT);

  logic [0:0]       state;
  logic [DRN_W-1:0] drain_cnt;
  logic [CNT_W-1:0] outstanding;
  logic             running;
  logic             credit_ok;
  logic             fire;
  logic             pop;
  logic             capture;
  logic             unexpected;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_unused;

  assign running         = (state == ST_RUN);
  assign credit_ok       = running && (used_cnt < CREDITS);
  assign s_axis_a_tready = credit_ok & s_axis_b_tvalid;
  assign s_axis_b_tready = credit_ok & s_axis_a_tvalid;
  assign fire            = credit_ok & s_axis_a_tvalid & s_axis_b_tvalid;

  assign m_axis_result_tvalid = ~fifo_empty;
  assign pop                  = m_axis_result_tvalid & m_axis_result_tready;

  // Results seen while draining belong to a previous life of the pipe.
  assign capture    = p_result_tvalid & running & (outstanding != '0);
  assign unexpected = p_result_tvalid & running & (outstanding == '0);

  // The FIFO can never overflow: every entry was pre-paid by a credit.
  assign fifo_unused = ^{fifo_count, fifo_full};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ST_DRAIN;
      drain_cnt <= '0;
    end else if (state == ST_DRAIN) begin
      if (drain_cnt == DRAIN_LAST) state <= ST_RUN;
      else                         drain_cnt <= drain_cnt + DRN_W'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      p_tvalid  <= 1'b0;
      p_a_tdata <= '0;
      p_b_tdata <= '0;
    end else begin
      p_tvalid <= fire;
      if (fire) begin
        p_a_tdata <= s_axis_a_tdata;
        p_b_tdata <= s_axis_b_tdata;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      used_cnt       <= '0;
      outstanding    <= '0;
      err_unexpected <= 1'b0;
    end else begin
      case ({fire, pop})
        2'b10:   used_cnt <= used_cnt + CNT_W'(1);
        2'b01:   used_cnt <= used_cnt - CNT_W'(1);
        default: used_cnt <= used_cnt;
      endcase
      case ({p_tvalid, capture})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
      if (unexpected) err_unexpected <= 1'b1;
    end
  end

  fpu_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_result_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .push  (capture),
    .din   (p_result_tdata),
    .pop   (pop),
    .dout  (m_axis_result_tdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

`default_nettype wire
